// File: rtl/regbank_wr_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : regbank_wr_arb_if
// Description : Write-request and read-port bundle for regbank_wr_arb.
//               Packed per-requester vectors (requester i at [i*W +: W]).
// Revision    : 1.0 - initial release
// ============================================================================
interface regbank_wr_arb_if #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int AW   = 3
);
  logic [NREQ-1:0]    req_vld;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_rdy;
  logic [AW-1:0]      rd_addr;
  logic [DW-1:0]      rd_data;
  logic               locked;
  logic [NREQ-1:0]    owner;

  modport master (
    output req_vld, req_lock, req_addr, req_data, rd_addr,
    input  req_rdy, rd_data, locked, owner
  );

  modport slave (
    input  req_vld, req_lock, req_addr, req_data, rd_addr,
    output req_rdy, rd_data, locked, owner
  );
endinterface
`default_nettype wire

// File: rtl/regbank_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : regbank_wr_arb
// Description : Round-robin write arbiter for a reset-to-zero register bank,
//               with an optional per-master lock for back-to-back beats and
//               one combinational read port.
//               Optional macro REGBANK_WR_ARB_BYPASS_EN forwards same-cycle
//               write data to rd_data when the addresses match.
// Revision    : 1.0 - initial release
// ============================================================================
module regbank_wr_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int AW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  regbank_wr_arb_if.slave  bus
);

  localparam int DEPTH = 2 ** AW;
  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [PW-1:0]   r_ptr;
  logic [NREQ-1:0] r_owner;

  logic [NREQ-1:0] w_grant;
  logic [PW-1:0]   w_gidx;
  logic            w_hs;
  logic            w_win_lock;
  logic [AW-1:0]   w_win_addr;
  logic [DW-1:0]   w_win_data;
  logic [PW-1:0]   w_ptr_nxt;
  logic [DW-1:0]   w_bank [DEPTH];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: enter LOCKED on a locking beat, leave on the owner's unlocking beat
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_hs && w_win_lock)  w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (w_hs && !w_win_lock) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Grant: round-robin scan from the pointer in IDLE, owner-only in LOCKED;
  // forced idle while reset is asserted
  always_comb begin
    int  sum;
    logic found;
    w_grant = '0;
    w_gidx  = '0;
    sum     = 0;
    found   = 1'b0;
    if (r_state == ST_IDLE) begin
      for (int k = 0; k < NREQ; k++) begin
        sum = int'(r_ptr) + k;
        if (sum >= NREQ) sum = sum - NREQ;
        if (!found && bus.req_vld[sum]) begin
          found        = 1'b1;
          w_grant[sum] = 1'b1;
          w_gidx       = PW'(sum);
        end
      end
    end else begin
      w_grant = r_owner & bus.req_vld;
      for (int k = 0; k < NREQ; k++) begin
        if (r_owner[k]) w_gidx = PW'(k);
      end
    end
    if (!rst_n) w_grant = '0;
  end

  assign w_hs       = |w_grant;
  assign w_win_lock = |(w_grant & bus.req_lock);
  assign w_win_addr = bus.req_addr[w_gidx*AW +: AW];
  assign w_win_data = bus.req_data[w_gidx*DW +: DW];
  assign w_ptr_nxt  = (w_gidx == PW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;

  // Priority pointer moves past the winner on every beat; in LOCKED the
  // winner is always the owner, so unlocking leaves it at owner+1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_ptr <= '0;
    else if (w_hs) r_ptr <= w_ptr_nxt;
  end

  // Lock owner captured on the locking beat, cleared on the unlocking beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= '0;
    end else if (w_hs) begin
      if (r_state == ST_IDLE && w_win_lock)       r_owner <= w_grant;
      else if (r_state == ST_LOCKED && !w_win_lock) r_owner <= '0;
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    logic [DW-1:0] r_q;
    // Load-enabled entry: only the address of the winning beat loads
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             r_q <= '0;
      else if (w_hs && w_win_addr == AW'(e))  r_q <= w_win_data;
    end
    assign w_bank[e] = r_q;
  end

  assign bus.req_rdy = w_grant;
  assign bus.locked  = (r_state == ST_LOCKED);
  assign bus.owner   = r_owner;

`ifdef REGBANK_WR_ARB_BYPASS_EN
  assign bus.rd_data = (w_hs && w_win_addr == bus.rd_addr) ? w_win_data
                                                           : w_bank[bus.rd_addr];
`else
  assign bus.rd_data = w_bank[bus.rd_addr];
`endif

endmodule
`default_nettype wire

// File: tb/tb_regbank_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regbank_wr_arb
// Description : Directed self-checking bench for regbank_wr_arb
//               (NREQ=4, DW=32, AW=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regbank_wr_arb;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  regbank_wr_arb_if #(.NREQ(4), .DW(32), .AW(3)) bus ();

  regbank_wr_arb #(.NREQ(4), .DW(32), .AW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic lk,
                       input logic [2:0] a, input logic [31:0] d);
    bus.req_vld[i]          = v;
    bus.req_lock[i]         = lk;
    bus.req_addr[i*3 +: 3]  = a;
    bus.req_data[i*32 +: 32] = d;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    bus.rd_addr = a;
    #1;
    chk(tag, bus.rd_data, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] byp_exp;
    total = 0;
    bad   = 0;
    bus.req_vld  = '0;
    bus.req_lock = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.rd_addr  = '0;
    rst_n = 1'b0;

    // ---- reset: rdy held low even with every vld high
    bus.req_vld = 4'b1111;
    #3;
    chk("rdy_in_reset", 32'(bus.req_rdy), 32'h0);
    tick();
    rst_n = 1'b1;
    bus.req_vld = '0;
    #1;
    chk("locked_reset", 32'(bus.locked), 32'h0);
    chk("owner_reset", 32'(bus.owner), 32'h0);
    chk("rdy_idle", 32'(bus.req_rdy), 32'h0);
    for (int a = 0; a < 8; a++) rd($sformatf("rd_reset_%0d", a), 3'(a), 32'h0);

    // ---- round robin with all four valid, distinct addresses
    for (int i = 0; i < 4; i++) drive(i, 1'b1, 1'b0, 3'(i), 32'hA0 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_rdy_%0d", i), 32'(bus.req_rdy), 32'h1 << i);
      rd($sformatf("rr_old_%0d", i), 3'(i), 32'h0);
      tick();
      bus.req_vld[i] = 1'b0;
      rd($sformatf("rr_new_%0d", i), 3'(i), 32'hA0 + 32'(i));
    end

    // ---- pointer wrapped to 0: req0 wins over req3, then req3
    drive(0, 1'b1, 1'b0, 3'd4, 32'hB0);
    drive(3, 1'b1, 1'b0, 3'd7, 32'hB3);
    #1;
    chk("wrap_rdy0", 32'(bus.req_rdy), 32'h1);
    tick();
    bus.req_vld[0] = 1'b0;
    #1;
    chk("wrap_rdy3", 32'(bus.req_rdy), 32'h8);
    tick();
    bus.req_vld[3] = 1'b0;
    rd("wrap_rd4", 3'd4, 32'hB0);
    rd("wrap_rd7", 3'd7, 32'hB3);

    // ---- move pointer to 2 via req1, then vld=0011 wraps to req0 first
    drive(1, 1'b1, 1'b0, 3'd6, 32'hC1);
    #1;
    chk("p2_rdy1", 32'(bus.req_rdy), 32'h2);
    tick();
    bus.req_vld[1] = 1'b0;
    drive(0, 1'b1, 1'b0, 3'd4, 32'hC0);
    drive(1, 1'b1, 1'b0, 3'd6, 32'hC2);
    #1;
    chk("p2_wrap_rdy0", 32'(bus.req_rdy), 32'h1);
    tick();
    bus.req_vld[0] = 1'b0;
    #1;
    chk("p1_rdy1", 32'(bus.req_rdy), 32'h2);
    tick();
    bus.req_vld[1] = 1'b0;
    rd("p_rd4", 3'd4, 32'hC0);
    rd("p_rd6", 3'd6, 32'hC2);

    // ---- lock: req1 takes three beats while req0/req2 wait (pointer = 2)
    drive(1, 1'b1, 1'b1, 3'd1, 32'hD1);
    #1;
    chk("lk_rdy_b1", 32'(bus.req_rdy), 32'h2);
    tick();
    chk("lk_locked_b1", 32'(bus.locked), 32'h1);
    chk("lk_owner_b1", 32'(bus.owner), 32'h2);
    drive(1, 1'b1, 1'b1, 3'd2, 32'hD2);
    drive(0, 1'b1, 1'b0, 3'd0, 32'hE0);
    drive(2, 1'b1, 1'b0, 3'd4, 32'hE2);
    #1;
    chk("lk_rdy_b2", 32'(bus.req_rdy), 32'h2);
    tick();
    chk("lk_locked_b2", 32'(bus.locked), 32'h1);
    rd("lk_rd2", 3'd2, 32'hD2);
    // owner idles two cycles: nobody granted, nothing written
    bus.req_vld[1] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("lk_gap_rdy_%0d", c), 32'(bus.req_rdy), 32'h0);
      chk($sformatf("lk_gap_locked_%0d", c), 32'(bus.locked), 32'h1);
      tick();
    end
    rd("lk_gap_rd0", 3'd0, 32'hA0);
    rd("lk_gap_rd4", 3'd4, 32'hC0);
    drive(1, 1'b1, 1'b0, 3'd3, 32'hD3);
    #1;
    chk("lk_rdy_b3", 32'(bus.req_rdy), 32'h2);
    tick();
    bus.req_vld[1] = 1'b0;
    chk("lk_locked_end", 32'(bus.locked), 32'h0);
    chk("lk_owner_end", 32'(bus.owner), 32'h0);
    rd("lk_rd3", 3'd3, 32'hD3);
    #1;
    chk("unlk_rdy2", 32'(bus.req_rdy), 32'h4);
    tick();
    bus.req_vld[2] = 1'b0;
    #1;
    chk("unlk_rdy0", 32'(bus.req_rdy), 32'h1);
    tick();
    bus.req_vld[0] = 1'b0;
    rd("unlk_rd4", 3'd4, 32'hE2);
    rd("unlk_rd0", 3'd0, 32'hE0);

    // ---- same-cycle write/read of address 5
`ifdef REGBANK_WR_ARB_BYPASS_EN
    byp_exp = 32'h55;
`else
    byp_exp = 32'h0;
`endif
    drive(3, 1'b1, 1'b0, 3'd5, 32'h55);
    #1;
    chk("byp_rdy3", 32'(bus.req_rdy), 32'h8);
    rd("byp_same_cycle", 3'd5, byp_exp);
    tick();
    bus.req_vld[3] = 1'b0;
    rd("byp_next_cycle", 3'd5, 32'h55);

    // ---- asynchronous reset while LOCKED with a beat pending
    drive(2, 1'b1, 1'b1, 3'd7, 32'h77);
    #1;
    chk("rst_lk_rdy2", 32'(bus.req_rdy), 32'h4);
    tick();
    chk("rst_lk_locked", 32'(bus.locked), 32'h1);
    drive(2, 1'b1, 1'b1, 3'd0, 32'h99);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_locked", 32'(bus.locked), 32'h0);
    chk("rst_owner", 32'(bus.owner), 32'h0);
    chk("rst_rdy", 32'(bus.req_rdy), 32'h0);
    rd("rst_rd0", 3'd0, 32'h0);
    rd("rst_rd7", 3'd7, 32'h0);
    tick();
    rst_n = 1'b1;
    bus.req_vld = '0;
    tick();
    rd("rst_after_rd0", 3'd0, 32'h0);
    bus.req_vld = 4'b1111;
    #1;
    chk("rst_ptr_rdy0", 32'(bus.req_rdy), 32'h1);
    bus.req_vld = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regbank_wr_arb.md
Name: regbank_wr_arb

Overview:
Round-robin write-port arbiter and sequencer for a shared register bank built from load-enabled, reset-to-zero flops. It collects write requests from NREQ masters, grants at most one per cycle, and writes the winner's data into the bank. One combinational read port is provided. An optional lock lets one master hold the port for back-to-back beats, for example multi-word config updates.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 32, data width per bank entry
AW, 3, address width; bank depth = 2**AW entries

Ports:
clk        input   1         clock
rst_n      input   1         asynchronous reset, active-low
req_vld    input   NREQ      per-requester write valid
req_lock   input   NREQ      per-requester lock request; sampled at handshake
req_addr   input   NREQ*AW   packed write addresses; requester i at [i*AW +: AW]
req_data   input   NREQ*DW   packed write data; requester i at [i*DW +: DW]
req_rdy    output  NREQ      one-hot grant/ready, combinational
rd_addr    input   AW        read address
rd_data    output  DW        read data, combinational from bank
locked     output  1         high while the FSM is in LOCKED
owner      output  NREQ      one-hot lock owner; 0 when IDLE

Behaviour:
- Clock is clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - All bank entries = 0.
  - Priority pointer = 0 (requester 0 highest).
  - FSM = IDLE, owner = 0, locked = 0.
  - req_rdy = 0 during reset.
- Handshake:
  - Beat i completes when req_vld[i] & req_rdy[i] at a rising edge.
  - Masters hold vld, addr, data and lock stable until the handshake.
  - req_rdy depends only on req_vld and state; never on rdy.
- Grant rule in IDLE:
  - Scan from the pointer upward, wrapping modulo NREQ.
  - The first requester with vld high gets rdy; only one rdy bit is ever high.
  - If no vld is high, req_rdy = 0.
- Pointer update:
  - On a handshake by requester i in IDLE, pointer <= (i+1) mod NREQ.
  - With no handshake, the pointer holds.
  - Wrap check: grant to NREQ-1 sets pointer to 0.
- Write:
  - On a handshake, bank[addr_i] <= data_i at that edge. Only the winning entry loads; all others hold.
  - Visible on rd_data from the next cycle (1-cycle write latency).
- FSM states:
  - IDLE: round-robin as above.
    - Handshake by i with req_lock[i]=1 -> LOCKED, owner = one-hot(i).
    - Handshake with lock=0 -> stay IDLE.
  - LOCKED: req_rdy = owner & req_vld; all other requesters are blocked.
    - Owner handshake with req_lock=1 -> stay LOCKED.
    - Owner handshake with req_lock=0 -> IDLE, and pointer <= owner+1.
    - Owner deasserts vld -> stay LOCKED; no grants are issued.
- Simultaneous events:
  - Several vld in the same cycle: exactly one is granted; the rest wait, with no data loss.
  - A read of an address written in the same cycle returns the old value (see Optional Feature).
- Reset mid-operation:
  - Immediately clears the bank, the FSM (-> IDLE) and the pointer.
  - An in-flight beat is not written.

Optional Feature:
REGBANK_WR_ARB_BYPASS_EN
- Defined:
  - rd_data forwards the winning req_data combinationally when a handshake occurs this cycle and its addr == rd_addr.
  - Otherwise rd_data returns the bank value.
- Undefined:
  - rd_data always returns the bank value, i.e. the old value during a same-address write.

Test Plan:
- Reset, then read all 8 addresses -> rd_data = 0; req_rdy = 0; locked = 0; pointer = 0.
- All 4 vld held, no lock, distinct addrs 0..3, data 0xA0..0xA3 -> grants in order 0,1,2,3, one per cycle; bank[0..3] = 0xA0..0xA3 one cycle after each grant; pointer wraps to 0.
- Pointer = 2, req_vld = 4'b0011 -> requester 0 granted (wrap), then pointer = 1, so requester 1 is granted next.
- Req 1 locks for 3 beats (lock=1,1,0) while reqs 0 and 2 are valid -> req_rdy = 4'b0010 for all 3 handshakes; locked = 1 until the third; then req 2 is granted next.
- Lock owner drops vld for 2 cycles mid-lock -> req_rdy = 0 for those cycles; locked stays 1; no other write occurs.
- Same-cycle write 0x55 to addr 5 with rd_addr = 5 -> rd_data = old value (0) without the macro, 0x55 with REGBANK_WR_ARB_BYPASS_EN; both give 0x55 the next cycle.
- Assert rst_n=0 asynchronously while LOCKED with a pending beat -> bank cleared, locked = 0, owner = 0, and the pending data is not written.
